// File: rtl/rgb_to_axis_video.sv
// RGB pixel stream to AXI4-Stream video bridge with a 2-entry skid FIFO and tuser/tlast framing.
// Define RGB_TO_AXIS_ERROR_COUNT_EN to build the saturating frame-error counter.
module rgb_to_axis_video #(
  parameter int Height = 2160,
  parameter int Width  = 3840
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        slave_valid_i,
  output logic        slave_ready_o,
  input  logic [7:0]  slave_red_i,
  input  logic [7:0]  slave_green_i,
  input  logic [7:0]  slave_blue_i,
  input  logic        slave_last_i,
  output logic        master_valid_o,
  input  logic        master_ready_i,
  output logic [23:0] master_data_o,
  output logic        master_user_o,
  output logic        master_last_o,
  output logic        frame_done_o,
  output logic        frame_error_o,
  output logic [15:0] error_count_o
);

  localparam int ColW = (Width  > 1) ? $clog2(Width)  : 1;
  localparam int RowW = (Height > 1) ? $clog2(Height) : 1;

  typedef struct packed {
    logic [23:0] data;
    logic        user;
    logic        last;
    logic        eof;
  } entry_t;

  entry_t          r_mem [2];
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [1:0]      r_count;
  logic            r_ready;
  logic [ColW-1:0] r_col;
  logic [RowW-1:0] r_row;
  logic            r_frame_done;
  logic            r_frame_error;

  logic            w_push;
  logic            w_pop;
  logic            w_col_end;
  logic            w_row_end;
  logic            w_eof;
  logic [1:0]      w_count_next;
  entry_t          w_in;
  entry_t          w_head;

  assign w_push    = slave_valid_i && r_ready;
  assign w_pop     = (r_count != 2'd0) && master_ready_i;
  assign w_col_end = (r_col == ColW'(Width - 1));
  assign w_row_end = (r_row == RowW'(Height - 1));
  assign w_eof     = w_col_end && w_row_end;
  assign w_head    = r_mem[r_rd_ptr];

  // An early slave_last_i still closes the frame, so it tags both tlast and end-of-frame.
  assign w_in.data = {slave_red_i, slave_green_i, slave_blue_i};
  assign w_in.user = (r_row == '0) && (r_col == '0);
  assign w_in.last = w_col_end || slave_last_i;
  assign w_in.eof  = w_eof || slave_last_i;

  always_comb begin
    // NOTE: default assignment first so every path drives w_count_next and no latch is inferred.
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      // NOTE: the two storage entries are reset so master_data_o and the flags read 0 during reset.
      r_mem[0]      <= '0;
      r_mem[1]      <= '0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_count       <= 2'd0;
      r_ready       <= 1'b0;
      r_col         <= '0;
      r_row         <= '0;
      r_frame_done  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_in;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count       <= w_count_next;
      r_ready       <= (w_count_next != 2'd2);
      r_frame_done  <= w_pop && w_head.eof;
      r_frame_error <= w_push && (slave_last_i != w_eof);

      if (w_push) begin
        if (slave_last_i || w_eof) begin
          r_col <= '0;
          r_row <= '0;
        end else if (w_col_end) begin
          r_col <= '0;
          r_row <= r_row + RowW'(1);
        end else begin
          r_col <= r_col + ColW'(1);
        end
      end
    end
  end

`ifdef RGB_TO_AXIS_ERROR_COUNT_EN
  logic [15:0] r_error_count;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_error_count <= 16'd0;
    end else if (r_frame_error && (r_error_count != 16'hFFFF)) begin
      r_error_count <= r_error_count + 16'd1;
    end
  end

  assign error_count_o = r_error_count;
`else
  assign error_count_o = 16'd0;
`endif

  assign slave_ready_o  = r_ready;
  assign master_valid_o = (r_count != 2'd0);
  assign master_data_o  = w_head.data;
  assign master_user_o  = w_head.user;
  assign master_last_o  = w_head.last;
  assign frame_done_o   = r_frame_done;
  assign frame_error_o  = r_frame_error;

endmodule

// File: tb/tb_rgb_to_axis_video.sv
// Directed bench for rgb_to_axis_video at Height=2, Width=3; expected beats are hand-written per pixel.
// Honours RGB_TO_AXIS_ERROR_COUNT_EN for the expected error_count_o.
module tb_rgb_to_axis_video;

  localparam int H = 2;
  localparam int W = 3;

`ifdef RGB_TO_AXIS_ERROR_COUNT_EN
  localparam int ErrCountEn = 1;
`else
  localparam int ErrCountEn = 0;
`endif

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        slave_valid_i = 1'b0;
  logic        slave_ready_o;
  logic [7:0]  slave_red_i = '0;
  logic [7:0]  slave_green_i = '0;
  logic [7:0]  slave_blue_i = '0;
  logic        slave_last_i = 1'b0;
  logic        master_valid_o;
  logic        master_ready_i = 1'b1;
  logic [23:0] master_data_o;
  logic        master_user_o;
  logic        master_last_o;
  logic        frame_done_o;
  logic        frame_error_o;
  logic [15:0] error_count_o;

  rgb_to_axis_video #(.Height(H), .Width(W)) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .slave_valid_i  (slave_valid_i),
    .slave_ready_o  (slave_ready_o),
    .slave_red_i    (slave_red_i),
    .slave_green_i  (slave_green_i),
    .slave_blue_i   (slave_blue_i),
    .slave_last_i   (slave_last_i),
    .master_valid_o (master_valid_o),
    .master_ready_i (master_ready_i),
    .master_data_o  (master_data_o),
    .master_user_o  (master_user_o),
    .master_last_o  (master_last_o),
    .frame_done_o   (frame_done_o),
    .frame_error_o  (frame_error_o),
    .error_count_o  (error_count_o)
  );

  always #5 clock_i = ~clock_i;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic [25:0] exp_q [$];
  logic [25:0] exp_beat;
  logic        hold_prev = 1'b0;
  logic [26:0] hold_val = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  always @(posedge clock_i) cyc++;

  // Output monitor: checks each master transfer against the expected queue and held-beat stability.
  always @(negedge clock_i) begin
    if (reset_i) begin
      hold_prev = 1'b0;
    end else begin
      if (frame_done_o)  done_cnt++;
      if (frame_error_o) err_cnt++;
      if (hold_prev)
        check("hold_stable", {5'd0, master_valid_o, master_user_o, master_last_o, master_data_o},
              {5'd0, hold_val});
      if (master_valid_o && master_ready_i) begin
        if (exp_q.size() == 0) begin
          check("spurious_xfer", {31'd0, master_valid_o}, 32'd0);
        end else begin
          exp_beat = exp_q.pop_front();
          check("xfer_beat", {6'd0, master_user_o, master_last_o, master_data_o}, {6'd0, exp_beat});
        end
      end
      hold_prev = master_valid_o && !master_ready_i;
      hold_val  = {master_valid_o, master_user_o, master_last_o, master_data_o};
    end
  end

  // Called just after a rising edge; returns just after the edge on which the pixel is accepted.
  task automatic send(input logic [23:0] d, input logic last_in, input logic exp_user,
                      input logic exp_last);
    int t;
    exp_q.push_back({exp_user, exp_last, d});
    {slave_red_i, slave_green_i, slave_blue_i} = d;
    slave_last_i  = last_in;
    slave_valid_i = 1'b1;
    t = 0;
    @(negedge clock_i);
    while (!slave_ready_o && t < 100) begin
      @(negedge clock_i);
      t++;
    end
    if (!slave_ready_o) check("send_timeout", {31'd0, slave_ready_o}, 32'd1);
    @(posedge clock_i);
    #1;
    slave_valid_i = 1'b0;
    slave_last_i  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clock_i);
    while (master_valid_o && t < 100) begin
      @(negedge clock_i);
      t++;
    end
    if (master_valid_o) check("drain_timeout", {31'd0, master_valid_o}, 32'd0);
    repeat (2) @(negedge clock_i);
    check("drain_queue_empty", exp_q.size(), 32'd0);
    @(posedge clock_i);
    #1;
  endtask

  int c0, d0, e0;

  initial begin
    // Reset state
    repeat (2) @(negedge clock_i);
    check("rst_slave_ready", {31'd0, slave_ready_o}, 32'd0);
    check("rst_master_valid", {31'd0, master_valid_o}, 32'd0);
    check("rst_data", {8'd0, master_data_o}, 32'd0);
    check("rst_user_last", {30'd0, master_user_o, master_last_o}, 32'd0);
    check("rst_pulses", {30'd0, frame_done_o, frame_error_o}, 32'd0);
    check("rst_err_count", {16'd0, error_count_o}, 32'd0);
    #1 reset_i = 1'b0;
    check("ready_not_comb", {31'd0, slave_ready_o}, 32'd0);
    @(posedge clock_i);
    #1;
    check("ready_rise", {31'd0, slave_ready_o}, 32'd1);

    // Full frame at full rate, one-cycle latency
    d0 = done_cnt; e0 = err_cnt; c0 = cyc;
    send(24'h010203, 1'b0, 1'b1, 1'b0);
    check("lat_valid", {31'd0, master_valid_o}, 32'd1);
    check("lat_data", {8'd0, master_data_o}, 32'h010203);
    send(24'h040506, 1'b0, 1'b0, 1'b0);
    send(24'h070809, 1'b0, 1'b0, 1'b1);
    send(24'h0A0B0C, 1'b0, 1'b0, 1'b0);
    send(24'h0D0E0F, 1'b0, 1'b0, 1'b0);
    send(24'h0E0F10, 1'b1, 1'b0, 1'b1);
    check("throughput_cycles", cyc - c0, 32'd6);
    check("frame1_no_err_pulse", {31'd0, frame_error_o}, 32'd0);
    drain();
    check("frame1_done", done_cnt - d0, 32'd1);
    check("frame1_err", err_cnt - e0, 32'd0);

    // Backpressure: downstream stalls for 5 cycles
    d0 = done_cnt; e0 = err_cnt;
    master_ready_i = 1'b0;
    send(24'h111111, 1'b0, 1'b1, 1'b0);
    send(24'h222222, 1'b0, 1'b0, 1'b0);
    check("bp_ready_low", {31'd0, slave_ready_o}, 32'd0);
    check("bp_valid", {31'd0, master_valid_o}, 32'd1);
    check("bp_head", {8'd0, master_data_o}, 32'h111111);
    repeat (3) @(posedge clock_i);
    #1;
    check("bp_hold_data", {8'd0, master_data_o}, 32'h111111);
    check("bp_ready_still_low", {31'd0, slave_ready_o}, 32'd0);
    master_ready_i = 1'b1;
    send(24'h333333, 1'b0, 1'b0, 1'b1);
    send(24'h444444, 1'b0, 1'b0, 1'b0);
    send(24'h555555, 1'b0, 1'b0, 1'b0);
    send(24'h666666, 1'b1, 1'b0, 1'b1);
    drain();
    check("bp_done", done_cnt - d0, 32'd1);
    check("bp_err", err_cnt - e0, 32'd0);

    // Early last on pixel 4
    d0 = done_cnt; e0 = err_cnt;
    send(24'hA10001, 1'b0, 1'b1, 1'b0);
    send(24'hA10002, 1'b0, 1'b0, 1'b0);
    send(24'hA10003, 1'b0, 1'b0, 1'b1);
    send(24'hA10004, 1'b1, 1'b0, 1'b1);
    check("early_err_pulse", {31'd0, frame_error_o}, 32'd1);
    send(24'hB10001, 1'b0, 1'b1, 1'b0);
    send(24'hB10002, 1'b0, 1'b0, 1'b0);
    send(24'hB10003, 1'b0, 1'b0, 1'b1);
    send(24'hB10004, 1'b0, 1'b0, 1'b0);
    send(24'hB10005, 1'b0, 1'b0, 1'b0);
    send(24'hB10006, 1'b1, 1'b0, 1'b1);
    drain();
    check("early_err_count_pulses", err_cnt - e0, 32'd1);
    check("early_done", done_cnt - d0, 32'd2);
    check("early_err_counter", {16'd0, error_count_o}, 32'(ErrCountEn));

    // Missing last at end-of-frame
    d0 = done_cnt; e0 = err_cnt;
    send(24'hC10001, 1'b0, 1'b1, 1'b0);
    send(24'hC10002, 1'b0, 1'b0, 1'b0);
    send(24'hC10003, 1'b0, 1'b0, 1'b1);
    send(24'hC10004, 1'b0, 1'b0, 1'b0);
    send(24'hC10005, 1'b0, 1'b0, 1'b0);
    send(24'hC10006, 1'b0, 1'b0, 1'b1);
    check("miss_err_pulse", {31'd0, frame_error_o}, 32'd1);
    send(24'hC10007, 1'b0, 1'b1, 1'b0);
    send(24'hC10008, 1'b0, 1'b0, 1'b0);
    send(24'hC10009, 1'b0, 1'b0, 1'b1);
    send(24'hC1000A, 1'b0, 1'b0, 1'b0);
    send(24'hC1000B, 1'b0, 1'b0, 1'b0);
    send(24'hC1000C, 1'b1, 1'b0, 1'b1);
    drain();
    check("miss_err_count_pulses", err_cnt - e0, 32'd1);
    check("miss_done", done_cnt - d0, 32'd2);
    check("miss_err_counter", {16'd0, error_count_o}, 32'(2 * ErrCountEn));

    // Reset mid-frame with two entries queued
    d0 = done_cnt; e0 = err_cnt;
    master_ready_i = 1'b0;
    send(24'hD10001, 1'b0, 1'b1, 1'b0);
    send(24'hD10002, 1'b0, 1'b0, 1'b0);
    check("prerst_ready_low", {31'd0, slave_ready_o}, 32'd0);
    reset_i = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_valid", {31'd0, master_valid_o}, 32'd0);
    check("midrst_ready", {31'd0, slave_ready_o}, 32'd0);
    check("midrst_data", {8'd0, master_data_o}, 32'd0);
    check("midrst_err_counter", {16'd0, error_count_o}, 32'd0);
    @(negedge clock_i);
    #1;
    reset_i = 1'b0;
    master_ready_i = 1'b1;
    @(posedge clock_i);
    #1;
    check("postrst_ready", {31'd0, slave_ready_o}, 32'd1);
    send(24'hE10001, 1'b0, 1'b1, 1'b0);
    send(24'hE10002, 1'b0, 1'b0, 1'b0);
    send(24'hE10003, 1'b0, 1'b0, 1'b1);
    send(24'hE10004, 1'b0, 1'b0, 1'b0);
    send(24'hE10005, 1'b0, 1'b0, 1'b0);
    send(24'hE10006, 1'b1, 1'b0, 1'b1);
    drain();
    check("postrst_done", done_cnt - d0, 32'd1);
    check("postrst_err", err_cnt - e0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/rgb_to_axis_video.md
RGB_TO_AXIS_VIDEO -- requirements
Module: rgb_to_axis_video

Interface
REQ-001 Parameter Height, default 2160: output frame rows, matching the 2x superresolution output height.
REQ-002 Parameter Width, default 3840: output frame columns, matching the 2x superresolution output width.
REQ-003 clock_i  in  1  single clock; all logic on its rising edge.
REQ-004 reset_i  in  1  asynchronous, active-high reset.
REQ-005 slave_valid_i  in  1  upstream pixel valid.
REQ-006 slave_ready_o  out  1  block can accept a pixel.
REQ-007 slave_red_i / slave_green_i / slave_blue_i  in  8 each  pixel components.
REQ-008 slave_last_i  in  1  upstream marks the final pixel of a frame.
REQ-009 master_valid_o  out  1  AXI4-Stream video tvalid.
REQ-010 master_ready_i  in  1  tready.
REQ-011 master_data_o  out  24  tdata = {red, green, blue}, with red in bits 23:16.
REQ-012 master_user_o  out  1  tuser, start of frame.
REQ-013 master_last_o  out  1  tlast, end of line.
REQ-014 frame_done_o  out  1  one-cycle pulse when a frame's final pixel transfers on the master side.
REQ-015 frame_error_o  out  1  one-cycle pulse on a frame-length mismatch.
REQ-016 error_count_o  out  16  saturating count of frame_error_o pulses.

Function
REQ-017 The block SHALL contain a 2-entry skid FIFO; an upstream transfer occurs when slave_valid_i && slave_ready_o.
REQ-018 The FIFO SHALL store each pixel with its computed user and last flags.
REQ-019 slave_ready_o SHALL be registered and high whenever fewer than 2 entries are occupied.
REQ-020 A pixel accepted in cycle N SHALL present on master_valid_o in cycle N+1 when the FIFO was empty; latency is 1.
REQ-021 master_valid_o SHALL be high whenever the FIFO is non-empty.
REQ-022 Once master_valid_o is high, master_data_o, master_user_o and master_last_o SHALL stay stable until master_ready_i is high.
REQ-023 A simultaneous upstream accept and downstream transfer SHALL keep occupancy unchanged.
REQ-024 Pixel order SHALL be preserved.
REQ-025 Full-throughput streaming (1 pixel/cycle) SHALL be sustained while master_ready_i stays high.
REQ-026 Input-side counters col (0..Width-1) and row (0..Height-1) SHALL advance on each upstream accept.
REQ-027 col SHALL wrap to 0 after Width-1 and increment row; row SHALL wrap to 0 after Height-1.
REQ-028 The user flag SHALL be 1 exactly when row==0 && col==0 at accept.
REQ-029 The last flag SHALL be 1 exactly when col==Width-1 at accept.
REQ-030 End-of-frame at accept SHALL be defined as row==Height-1 && col==Width-1.
REQ-031 Early last (slave_last_i=1 before end-of-frame): frame_error_o SHALL pulse the next cycle, and counters SHALL reset to 0 so the next pixel is start of frame.
REQ-032 Early last: the early pixel SHALL carry the tlast flag.
REQ-033 Missing last (end-of-frame with slave_last_i=0): frame_error_o SHALL pulse the next cycle, and counters SHALL wrap normally.
REQ-034 frame_done_o SHALL pulse in the cycle after a master transfer of an entry tagged end-of-frame, including an early last.
REQ-035 error_count_o SHALL saturate at 16'hFFFF.

Reset
REQ-036 While reset_i is high, slave_ready_o, master_valid_o, master_user_o, master_last_o, frame_done_o and frame_error_o SHALL be 0.
REQ-037 While reset_i is high, master_data_o, FIFO occupancy, row, col and error_count_o SHALL be 0.
REQ-038 Reset asserted mid-frame SHALL discard FIFO contents, and the first pixel accepted after release SHALL carry user=1.
REQ-039 slave_ready_o SHALL rise on the first clock edge after reset_i deasserts.

Configuration
REQ-040 With RGB_TO_AXIS_ERROR_COUNT_EN defined, error_count_o SHALL behave per REQ-016 and REQ-035.
REQ-041 Without RGB_TO_AXIS_ERROR_COUNT_EN, error_count_o SHALL be tied to 0, no counter register SHALL exist, and frame_error_o SHALL be unaffected.

Verification (Height=2, Width=3)
REQ-042 Six pixels 0x010203..0x0E0F10 with last on the 6th, ready held high: outputs one cycle delayed; user on pixel 1; tlast on pixels 3 and 6; frame_done_o pulses once; no error.
REQ-043 master_ready_i low for 5 cycles mid-stream: slave_ready_o drops after 2 accepts; held data stays stable; no pixel lost or duplicated after ready returns.
REQ-044 slave_last_i on pixel 4: frame_error_o pulses once; pixel 4 carries tlast; next pixel carries user=1; error_count_o=1.
REQ-045 Six pixels with no last: frame_error_o pulses after pixel 6; pixel 7 carries user=1.
REQ-046 reset_i pulsed after pixel 2 with 2 entries queued: master_valid_o drops immediately; the next accepted pixel carries user=1.
REQ-047 Build without RGB_TO_AXIS_ERROR_COUNT_EN and repeat REQ-044: frame_error_o pulses once; error_count_o stays 0.
